// File: rtl/output_module.sv
// Four-port registered output block: per-port EMPTY/FULL handshake with a
// consumer acknowledge, sticky overrun flags and a combinational busy hint.
module output_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       sel_port,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       ack,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] out_p0,
    output logic [WIDTH-1:0] out_p1,
    output logic [WIDTH-1:0] out_p2,
    output logic [WIDTH-1:0] out_p3,
    output logic [3:0]       valid,
    output logic [3:0]       overrun,
    output logic             busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    port_state_t      state_q [4];
    port_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [3:0]       ovr_q;
    logic [3:0]       wr_hit;
    logic [3:0]       ovr_set;

    always_comb begin
        wr_hit = '0;
        if (we) begin
            wr_hit[sel_port] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // An ack on an EMPTY port is ignored; a write always leaves the port FULL.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (wr_hit[i]) begin
                        state_d[i] = FULL;
                    end
                end
                FULL: begin
                    if (wr_hit[i]) begin
                        state_d[i] = FULL;
                    end else if (ack[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_comb begin
        valid   = '0;
        ovr_set = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            valid[i]   = (state_q[i] == FULL);
            ovr_set[i] = (state_q[i] == FULL) && wr_hit[i] && !ack[i];
        end
        busy = valid[sel_port];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_hit[i]) begin
                    data_q[i] <= data_in;
                end
            end
        end
    end

    // A fresh overrun takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_set | (ovr_q & {4{~clr_ovr}});
        end
    end

    assign overrun = ovr_q;
    assign out_p0  = data_q[0];
    assign out_p1  = data_q[1];
    assign out_p2  = data_q[2];
    assign out_p3  = data_q[3];

endmodule

// File: tb/tb_output_module.sv
// Self-checking bench for output_module: reference model plus directed
// vectors with hand-computed expectations.
module tb_output_module;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             we;
    logic [1:0]       sel_port;
    logic [WIDTH-1:0] data_in;
    logic [3:0]       ack;
    logic             clr_ovr;
    logic [WIDTH-1:0] out_p0, out_p1, out_p2, out_p3;
    logic [3:0]       valid;
    logic [3:0]       overrun;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic running = 1'b1;

    output_module #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .we(we), .sel_port(sel_port),
        .data_in(data_in), .ack(ack), .clr_ovr(clr_ovr),
        .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
        .valid(valid), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: port contents, pending-data flag and sticky overrun.
    logic [WIDTH-1:0] m_data [4];
    logic [3:0]       m_valid;
    logic [3:0]       m_ovr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_data[i] = '0;
            m_valid = '0;
            m_ovr   = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we && sel_port == 2'(i)) begin
                    m_ovr[i]   = (m_valid[i] && !ack[i]) || (m_ovr[i] && !clr_ovr);
                    m_data[i]  = data_in;
                    m_valid[i] = 1'b1;
                end else begin
                    m_ovr[i] = m_ovr[i] && !clr_ovr;
                    if (ack[i]) m_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check("model_p0", 32'(out_p0), 32'(m_data[0]));
            check("model_p1", 32'(out_p1), 32'(m_data[1]));
            check("model_p2", 32'(out_p2), 32'(m_data[2]));
            check("model_p3", 32'(out_p3), 32'(m_data[3]));
            check("model_valid", 32'(valid), 32'(m_valid));
            check("model_overrun", 32'(overrun), 32'(m_ovr));
            check("model_busy", 32'(busy), 32'(m_valid[sel_port]));
        end
    end

    // Drive one cycle of inputs and return 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] a, input logic c);
        we = w; sel_port = s; data_in = d; ack = a; clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {out_p0, out_p1, out_p2, out_p3}, 32'h0);
        check({name, "_flags"}, 32'({valid, overrun}), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        we = 0; sel_port = 0; data_in = 0; ack = 0; clr_ovr = 0;

        // Reset held with random inputs toggling.
        for (int n = 0; n < 6; n++) begin
            cyc(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
            check_all_zero("reset_hold");
        end
        we = 0; ack = 0; clr_ovr = 0;
        reset = 1'b1;
        cyc(0, 0, 8'h00, 4'b0000, 0);
        cyc(0, 0, 8'h00, 4'b0000, 0);
        check_all_zero("post_reset");

        // Basic write and ack.
        cyc(1, 2, 8'hA5, 4'b0000, 0);
        check("wr_p2", 32'(out_p2), 32'hA5);
        check("wr_valid", 32'(valid), 32'h4);
        check("wr_others", {out_p0, out_p1, out_p3}, 32'h0);
        cyc(0, 0, 8'h00, 4'b0100, 0);
        check("ack_valid", 32'(valid), 32'h0);
        check("ack_p2_kept", 32'(out_p2), 32'hA5);

        // Overrun, then clear.
        cyc(1, 1, 8'h11, 4'b0000, 0);
        cyc(1, 1, 8'h22, 4'b0000, 0);
        check("ovr_p1", 32'(out_p1), 32'h22);
        check("ovr_valid", 32'(valid), 32'h2);
        check("ovr_flag", 32'(overrun), 32'h2);
        cyc(0, 0, 8'h00, 4'b0000, 1);
        check("clr_flag", 32'(overrun), 32'h0);
        check("clr_valid", 32'(valid), 32'h2);
        cyc(0, 0, 8'h00, 4'b0010, 0);

        // Write with ack on a FULL port: no overrun.
        cyc(1, 3, 8'h33, 4'b0000, 0);
        cyc(1, 3, 8'h44, 4'b1000, 0);
        check("wack_p3", 32'(out_p3), 32'h44);
        check("wack_valid", 32'(valid), 32'h8);
        check("wack_ovr", 32'(overrun), 32'h0);
        cyc(0, 0, 8'h00, 4'b1000, 0);

        // Mixed ports and busy.
        cyc(1, 0, 8'h66, 4'b0000, 0);
        we = 0; sel_port = 0;
        #1;
        check("busy_p0", 32'(busy), 32'h1);
        sel_port = 1;
        #1;
        check("busy_p1_idle", 32'(busy), 32'h0);
        cyc(1, 1, 8'h55, 4'b0001, 0);
        check("mix_valid", 32'(valid), 32'h2);
        check("mix_p1", 32'(out_p1), 32'h55);
        cyc(0, 0, 8'h00, 4'b0100, 0);
        check("stray_valid", 32'(valid), 32'h2);
        check("stray_ovr", 32'(overrun), 32'h0);

        // Clear and new overrun in one cycle: set wins.
        cyc(1, 1, 8'h77, 4'b0000, 1);
        check("setwins_ovr", 32'(overrun), 32'h2);
        check("setwins_p1", 32'(out_p1), 32'h77);

        // Fill all ports, then reset between edges mid-write.
        cyc(1, 0, 8'h01, 4'b0000, 0);
        cyc(1, 2, 8'h02, 4'b0000, 0);
        cyc(1, 3, 8'h03, 4'b0000, 0);
        check("full_valid", 32'(valid), 32'hF);
        we = 1; sel_port = 2; data_in = 8'hEE;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        cyc(1, 2, 8'hEE, 4'b0000, 0);
        check_all_zero("reset_write_dropped");
        reset = 1'b1;
        cyc(1, 0, 8'h9C, 4'b0000, 0);
        check("first_after_reset", 32'(out_p0), 32'h9C);
        cyc(0, 0, 8'h00, 4'b0000, 0);

        @(negedge clk);
        running = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
